dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Shares the single AHB-lite-style data-memory bus between two requesters: the core load/store path (port 0, fed by the store/load units) and a DMA/debug master (port 1).
- Each request is sequenced through a pipelined address phase and data phase, with wait-state stalls on hready.
- Round-robin arbitration when both ports request.
- A wait-state watchdog aborts hung transfers and reports an error to the owning requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 16, consecutive hready-low cycles in the data phase before abort (legal range 2..255).

Ports:
- ms_riscv32_mp_clk_in  input  1  single clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset.
- req_in  input  2  per-port request (bit0 core, bit1 DMA); held until gnt.
- wr_in  input  2  per-port write(1)/read(0).
- addr0_in / addr1_in  input  ADDR_W  per-port word-aligned address.
- wdata0_in / wdata1_in  input  DATA_W  per-port write data; held until done.
- wmask0_in / wmask1_in  input  4  per-port byte strobes.
- gnt_out  output  2  one-hot, combinational; request accepted this cycle.
- done_out  output  2  one-cycle pulse; transfer completed.
- err_out  output  2  one-cycle pulse; transfer aborted by timeout.
- rdata_out  output  DATA_W  read data; valid with done_out on a read.
- ahb_haddr_out  output  ADDR_W  registered address phase.
- ahb_htrans_out  output  2  2'b00 IDLE, 2'b10 NONSEQ.
- ahb_hwrite_out  output  1  registered.
- ahb_hwstrb_out  output  4  registered with address phase.
- ahb_hwdata_out  output  DATA_W  driven during the data phase.
- ahb_hready_in  input  1  phase completes when high.
- ahb_hrdata_in  input  DATA_W  read data.

Behaviour:
- Reset, asserted asynchronously:
  - htrans=00; haddr, hwrite, hwstrb, hwdata, rdata_out=0.
  - gnt, done, err=0; both phase registers empty.
  - last_grant=1, so the core wins the first contention.
  - Timeout counter=0.
  - Reset mid-transfer discards everything; no done/err is issued.
- Address slot free = address-phase register empty, OR (occupied AND ahb_hready_in=1).
- Arbitration, combinational when the slot is free:
  - Single requester wins.
  - If both request, the port != last_grant wins.
  - gnt_out is asserted for the winner; last_grant updates at the clock edge.
  - No grant while the slot is not free.
- Cycle N (gnt): request captured at the edge. Cycle N+1: htrans=10 with haddr/hwrite/hwstrb of the winner. Held stable while ahb_hready_in=0.
- Address-phase completion (hready=1):
  - Transfer moves to the data-phase register (owner id, wr, wdata).
  - htrans returns to 00 unless a new grant occurred in the same cycle; back-to-back grants give continuous NONSEQ.
- Data phase:
  - hwdata = owner's wdata for writes, 0 for reads.
  - Completes on hready=1: done_out[owner] pulses; on a read, rdata_out <= hrdata_in at that edge and holds until the next read completion.
  - Minimum latency with zero wait states: gnt at N, done at N+2.
- At most one address phase plus one data phase in flight. A requester must not re-request before its done/err; the arbiter does not check this.
- Timeout:
  - Counter increments each data-phase cycle with hready=0 and clears on completion.
  - On reaching TIMEOUT_CYCLES: err_out[owner] pulses, the data phase is dropped, and any pending address phase is dropped with err to its owner in the same cycle. htrans=00 the next cycle; done is never issued for aborted transfers.
- Simultaneous completion of the data phase and the address phase in one cycle is legal; the pipeline advances with no bubble.

Test Plan:
- Core write alone: addr0=0x100, wdata0=0xDEADBEEF, wmask0=4'b1111, hready always 1 -> gnt_out=01 at N; htrans=10, haddr=0x100 at N+1; hwdata=0xDEADBEEF at N+2; done_out=01 at N+2.
- Both request reads every cycle, hready=1 -> grants alternate 01,10,01,... starting with core; htrans stays 10 continuously; done pulses alternate with 2-cycle latency.
- DMA read, hready low 3 cycles in data phase, hrdata=0x12345678 -> done_out=10 exactly when hready returns; rdata_out=0x12345678; no err.
- hready held low in address phase 4 cycles -> haddr/htrans stable for all 4 cycles; no new gnt until hready=1.
- Data phase stuck, hready=0 for TIMEOUT_CYCLES=16 -> err_out pulses for owner at the 16th stall cycle; htrans=00 the next cycle; no done.
- Reset asserted mid-data phase -> all outputs 0 immediately; after release, first contention grants core.

Source files
------------

// File: rtl/dmem_bus_arbiter.sv
// Two-port arbiter for the data-memory bus. Port 0 is the core load/store
// path and port 1 is the DMA/debug master. Accepted requests go through an
// address-phase slot and then a data-phase slot, both stalled by
// ahb_hready_in. If the data phase stalls too long, a watchdog aborts
// everything that is in flight.
module dmem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic [1:0]            req_in,
  input  logic [1:0]            wr_in,
  input  logic [ADDR_W-1:0]     addr0_in,
  input  logic [ADDR_W-1:0]     addr1_in,
  input  logic [DATA_W-1:0]     wdata0_in,
  input  logic [DATA_W-1:0]     wdata1_in,
  input  logic [DATA_W/8-1:0]   wmask0_in,
  input  logic [DATA_W/8-1:0]   wmask1_in,
  output logic [1:0]            gnt_out,
  output logic [1:0]            done_out,
  output logic [1:0]            err_out,
  output logic [DATA_W-1:0]     rdata_out,
  output logic [ADDR_W-1:0]     ahb_haddr_out,
  output logic [1:0]            ahb_htrans_out,
  output logic                  ahb_hwrite_out,
  output logic [DATA_W/8-1:0]   ahb_hwstrb_out,
  output logic [DATA_W-1:0]     ahb_hwdata_out,
  input  logic                  ahb_hready_in,
  input  logic [DATA_W-1:0]     ahb_hrdata_in
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  // The watchdog fires on the stall cycle whose count would reach TIMEOUT_CYCLES.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Per-port views of the request fields, so the winner can be chosen by index.
  logic [ADDR_W-1:0] port_addr  [2];
  logic [DATA_W-1:0] port_wdata [2];
  logic [STRB_W-1:0] port_strb  [2];

  assign port_addr[0]  = addr0_in;
  assign port_addr[1]  = addr1_in;
  assign port_wdata[0] = wdata0_in;
  assign port_wdata[1] = wdata1_in;
  assign port_strb[0]  = wmask0_in;
  assign port_strb[1]  = wmask1_in;

  // Address-phase slot.
  logic              a_valid_reg;
  logic              a_owner_reg;
  logic              a_wr_reg;
  logic [ADDR_W-1:0] a_addr_reg;
  logic [STRB_W-1:0] a_strb_reg;
  logic [DATA_W-1:0] a_wdata_reg;

  // Data-phase slot.
  logic              d_valid_reg;
  logic              d_owner_reg;
  logic              d_wr_reg;
  logic [DATA_W-1:0] d_wdata_reg;

  logic              last_grant_reg;
  logic [7:0]        stall_cnt_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              data_done;
  logic              timeout_hit;
  logic              slot_free;
  logic              grant_any;
  logic              win_port;

  // A data phase completes on any cycle with hready high.
  assign data_done = d_valid_reg && ahb_hready_in;

  // The watchdog fires on the last allowed stall cycle of a data phase.
  assign timeout_hit = d_valid_reg && !ahb_hready_in && (stall_cnt_reg == TO_LAST);

  // No grant is made in the abort cycle, so the bus is idle on the cycle
  // after an abort.
  assign slot_free = (!a_valid_reg || ahb_hready_in) && !timeout_hit;

  // Round-robin choice. Under contention the port that did not win last time
  // gets the grant. gnt is held low while reset is asserted.
  always_comb begin
    grant_any = 1'b0;
    win_port  = 1'b0;
    if (ms_riscv32_mp_rst_in && slot_free) begin
      unique case (req_in)
        2'b01: begin
          grant_any = 1'b1;
          win_port  = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          win_port  = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
          win_port  = !last_grant_reg;
        end
        default: begin
          grant_any = 1'b0;
          win_port  = 1'b0;
        end
      endcase
    end
  end

  // Per-port one-hot handshake outputs.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt_out[gi]  = grant_any && (win_port == 1'(gi));
    assign done_out[gi] = data_done && (d_owner_reg == 1'(gi));
    assign err_out[gi]  = timeout_hit &&
                          ((d_owner_reg == 1'(gi)) ||
                           (a_valid_reg && (a_owner_reg == 1'(gi))));
  end

  // Load the address slot on a grant, and release it when the address phase
  // completes or the transfer is aborted.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      a_valid_reg <= 1'b0;
      a_owner_reg <= 1'b0;
      a_wr_reg    <= 1'b0;
      a_addr_reg  <= '0;
      a_strb_reg  <= '0;
      a_wdata_reg <= '0;
    end else if (timeout_hit) begin
      a_valid_reg <= 1'b0;
    end else if (grant_any) begin
      a_valid_reg <= 1'b1;
      a_owner_reg <= win_port;
      a_wr_reg    <= wr_in[win_port];
      a_addr_reg  <= port_addr[win_port];
      a_strb_reg  <= port_strb[win_port];
      a_wdata_reg <= port_wdata[win_port];
    end else if (a_valid_reg && ahb_hready_in) begin
      a_valid_reg <= 1'b0;
    end
  end

  // When hready is high, the data slot retires its transfer and takes the
  // address slot's transfer, if there is one.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      d_valid_reg <= 1'b0;
      d_owner_reg <= 1'b0;
      d_wr_reg    <= 1'b0;
      d_wdata_reg <= '0;
    end else if (timeout_hit) begin
      d_valid_reg <= 1'b0;
    end else if (ahb_hready_in) begin
      d_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        d_owner_reg <= a_owner_reg;
        d_wr_reg    <= a_wr_reg;
        d_wdata_reg <= a_wdata_reg;
      end
    end
  end

  // Count consecutive data-phase stall cycles for the watchdog.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      stall_cnt_reg <= '0;
    end else if (!d_valid_reg || ahb_hready_in || timeout_hit) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end
  end

  // Record the last winner for round-robin fairness.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      last_grant_reg <= 1'b1;
    end else if (grant_any) begin
      last_grant_reg <= win_port;
    end
  end

  // Keep the most recent completed read data.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      rdata_reg <= '0;
    end else if (data_done && !d_wr_reg) begin
      rdata_reg <= ahb_hrdata_in;
    end
  end

  // Bus-side outputs. The address phase comes straight from the slot
  // registers. Read data is forwarded in the completion cycle, so rdata_out
  // is valid together with done_out.
  assign ahb_haddr_out  = a_addr_reg;
  assign ahb_hwrite_out = a_wr_reg;
  assign ahb_hwstrb_out = a_strb_reg;
  assign ahb_htrans_out = a_valid_reg ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_hwdata_out = (d_valid_reg && d_wr_reg) ? d_wdata_reg : '0;
  assign rdata_out      = (data_done && !d_wr_reg) ? ahb_hrdata_in : rdata_reg;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter. It runs directed vector tables,
// hand-written multi-cycle sequences, and random traffic checked against a
// transaction-queue reference model.
module tb_dmem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, wr;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  wmask0, wmask1;
  logic [1:0]  gnt, done, err;
  logic [31:0] rdata, haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready;
  logic [3:0]  hwstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .req_in(req),
    .wr_in(wr),
    .addr0_in(addr0),
    .addr1_in(addr1),
    .wdata0_in(wdata0),
    .wdata1_in(wdata1),
    .wmask0_in(wmask0),
    .wmask1_in(wmask1),
    .gnt_out(gnt),
    .done_out(done),
    .err_out(err),
    .rdata_out(rdata),
    .ahb_haddr_out(haddr),
    .ahb_htrans_out(htrans),
    .ahb_hwrite_out(hwrite),
    .ahb_hwstrb_out(hwstrb),
    .ahb_hwdata_out(hwdata),
    .ahb_hready_in(hready),
    .ahb_hrdata_in(hrdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled 3
  // time units later, well away from either clock edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    hready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic        hready;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        chk_rd;
  } vec_t;

  vec_t tbl[12];

  typedef struct {
    logic        owner;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        in_data;
  } xfer_t;

  xfer_t       pipe[$];
  int          stalls;
  logic        m_last;
  logic [31:0] m_rdata;
  int          pst[2];
  logic        pwr[2];
  logic [31:0] paddr[2], pwd[2];
  logic [3:0]  pstrb[2];
  int          hang;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] tmp;
    logic has_data, has_addr, abort, free, win;
    logic [1:0]  e_gnt, e_done, e_err;
    logic [31:0] e_rd, e_hw;
    xfer_t nx;

    rst_n = 1'b1; req = 0; wr = 0; hready = 1'b1; hrdata = 0;
    addr0 = 32'h100; addr1 = 32'h200;
    wdata0 = 32'hDEADBEEF; wdata1 = 32'hCAFEF00D;
    wmask0 = 4'b1111; wmask1 = 4'b0011;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    chk("reset htrans", 32'(htrans), 0);
    chk("reset haddr", haddr, 0);
    chk("reset hwdata", hwdata, 0);
    chk("reset rdata", rdata, 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    chk("reset gnt", 32'(gnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rows 0-7: both ports read continuously, then stop. Rows 8-11: the core
    // writes alone.
    tbl[0]  = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 32'h0,   32'h0, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b00, 2'b10, 32'h100, 32'h0, 1'b0};
    tbl[2]  = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10, 32'h200, 32'h0, 1'b1};
    tbl[3]  = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b10, 2'b10, 32'h100, 32'h0, 1'b1};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10, 32'h200, 32'h0, 1'b1};
    tbl[5]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 2'b10, 32'h100, 32'h0, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 32'h0,   32'h0, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0,   32'h0, 1'b0};
    tbl[8]  = '{2'b01, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 32'h0,   32'h0, 1'b0};
    tbl[9]  = '{2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b10, 32'h100, 32'h0, 1'b0};
    tbl[10] = '{2'b00, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 32'h0,   32'hDEADBEEF, 1'b0};
    tbl[11] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0,   32'h0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      req = tbl[i].req; wr = tbl[i].wr; hready = tbl[i].hready;
      hrdata = 32'h1000_0000 + 32'(i);
      #3;
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d err", i), 32'(err), 0);
      chk($sformatf("vec%0d htrans", i), 32'(htrans), 32'(tbl[i].htrans));
      if (tbl[i].htrans == 2'b10) chk($sformatf("vec%0d haddr", i), haddr, tbl[i].haddr);
      chk($sformatf("vec%0d hwdata", i), hwdata, tbl[i].hwdata);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d rdata", i), rdata, 32'h1000_0000 + 32'(i));
    end

    // DMA read with three data-phase wait states.
    next_cycle(); req = 2'b10; wr = 2'b00; hready = 1'b1; #3;
    chk("dmawait gnt", 32'(gnt), 32'(2'b10));
    next_cycle(); req = 2'b00; #3;
    chk("dmawait haddr", haddr, 32'h200);
    chk("dmawait hwrite", 32'(hwrite), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); hready = 1'b0; #3;
      chk("dmawait stall done", 32'(done), 0);
      chk("dmawait stall err", 32'(err), 0);
    end
    next_cycle(); hready = 1'b1; hrdata = 32'h12345678; #3;
    chk("dmawait done", 32'(done), 32'(2'b10));
    chk("dmawait err", 32'(err), 0);
    chk("dmawait rdata", rdata, 32'h12345678);
    next_cycle(); hrdata = 32'hFFFF0000; #3;
    chk("dmawait rdata hold", rdata, 32'h12345678);
    chk("dmawait no done", 32'(done), 0);

    // Address phase stalled for four cycles while the DMA port waits.
    next_cycle(); req = 2'b01; wr = 2'b00; hready = 1'b1; #3;
    chk("astall gnt0", 32'(gnt), 32'(2'b01));
    for (int k = 0; k < 4; k++) begin
      next_cycle(); req = 2'b10; hready = 1'b0; #3;
      chk("astall gnt", 32'(gnt), 0);
      chk("astall htrans", 32'(htrans), 32'(2'b10));
      chk("astall haddr", haddr, 32'h100);
    end
    next_cycle(); hready = 1'b1; #3;
    chk("astall release gnt", 32'(gnt), 32'(2'b10));
    chk("astall release done", 32'(done), 0);
    next_cycle(); req = 2'b00; #3;
    chk("astall core done", 32'(done), 32'(2'b01));
    chk("astall dma haddr", haddr, 32'h200);
    next_cycle(); #3;
    chk("astall dma done", 32'(done), 32'(2'b10));
    chk("astall idle", 32'(htrans), 0);

    // Watchdog: the core write hangs in the data phase while a DMA write
    // waits in the address phase.
    next_cycle(); req = 2'b01; wr = 2'b11; hready = 1'b1; #3;
    chk("tmo gnt core", 32'(gnt), 32'(2'b01));
    next_cycle(); req = 2'b10; #3;
    chk("tmo gnt dma", 32'(gnt), 32'(2'b10));
    for (int k = 1; k <= TIMEOUT; k++) begin
      next_cycle(); req = 2'b00; hready = 1'b0; #3;
      chk($sformatf("tmo stall%0d err", k), 32'(err), (k == TIMEOUT) ? 32'(2'b11) : 32'h0);
      chk($sformatf("tmo stall%0d done", k), 32'(done), 0);
      if (k == 1) begin
        chk("tmo hwdata", hwdata, 32'hDEADBEEF);
        chk("tmo hwstrb", 32'(hwstrb), 32'(4'b0011));
      end
    end
    next_cycle(); hready = 1'b1; #3;
    chk("tmo after htrans", 32'(htrans), 0);
    chk("tmo after done", 32'(done), 0);
    chk("tmo after err", 32'(err), 0);
    chk("tmo after hwdata", hwdata, 0);

    // Reset asserted in the middle of a data phase.
    next_cycle(); req = 2'b01; wr = 2'b01; #3;
    chk("rstmid gnt", 32'(gnt), 32'(2'b01));
    next_cycle(); req = 2'b00;
    next_cycle(); #3;
    chk("rstmid hwdata pre", hwdata, 32'hDEADBEEF);
    rst_n = 1'b0; req = 2'b11; #1;
    chk("rstmid gnt", 32'(gnt), 0);
    chk("rstmid done", 32'(done), 0);
    chk("rstmid err", 32'(err), 0);
    chk("rstmid htrans", 32'(htrans), 0);
    chk("rstmid haddr", haddr, 0);
    chk("rstmid hwdata", hwdata, 0);
    chk("rstmid rdata", rdata, 0);
    next_cycle(); rst_n = 1'b1; #3;
    chk("rstmid first gnt", 32'(gnt), 32'(2'b01));
    next_cycle(); req = 2'b10; #3;
    chk("rstmid no stale done", 32'(done), 0);
    chk("rstmid dma gnt", 32'(gnt), 32'(2'b10));
    next_cycle(); req = 2'b00;
    repeat (3) next_cycle();

    // Random traffic against the queue model.
    do_reset();
    pipe.delete(); stalls = 0; m_last = 1'b1; m_rdata = 0; hang = 0;
    pst[0] = 0; pst[1] = 0;
    for (int p = 0; p < 2; p++) begin
      pwr[p] = 0; paddr[p] = 0; pwd[p] = 0; pstrb[p] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (pst[p] == 0 && $urandom_range(0, 2) == 0) begin
          pst[p] = 1;
          pwr[p] = 1'($urandom_range(0, 1));
          tmp = $urandom;
          paddr[p] = tmp & 32'hFFFF_FFFC;
          pwd[p] = $urandom;
          pstrb[p] = 4'($urandom_range(0, 15));
        end
      end
      req = {pst[1] == 1, pst[0] == 1};
      wr = {pwr[1], pwr[0]};
      addr0 = paddr[0]; addr1 = paddr[1];
      wdata0 = pwd[0]; wdata1 = pwd[1];
      wmask0 = pstrb[0]; wmask1 = pstrb[1];
      if (hang > 0) begin
        hready = 1'b0; hang--;
      end else if ($urandom_range(0, 59) == 0) begin
        hready = 1'b0; hang = $urandom_range(13, 19);
      end else begin
        hready = ($urandom_range(0, 3) != 0);
      end
      hrdata = $urandom;
      #3;

      has_data = (pipe.size() > 0) && pipe[0].in_data;
      has_addr = (pipe.size() > 0) && !pipe[pipe.size()-1].in_data;
      e_gnt = 0; e_done = 0; e_err = 0;
      abort = has_data && !hready && (stalls + 1 >= TIMEOUT);
      if (has_data && hready) e_done[pipe[0].owner] = 1'b1;
      if (abort) foreach (pipe[i]) e_err[pipe[i].owner] = 1'b1;
      free = (!has_addr || hready) && !abort;
      win = 1'b0;
      if (free && req != 2'b00) begin
        win = (req == 2'b11) ? !m_last : req[1];
        e_gnt[win] = 1'b1;
      end
      e_rd = (has_data && hready && !pipe[0].wr) ? hrdata : m_rdata;
      e_hw = (has_data && pipe[0].wr) ? pipe[0].wdata : 32'h0;

      chk("rnd gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd done", 32'(done), 32'(e_done));
      chk("rnd err", 32'(err), 32'(e_err));
      chk("rnd htrans", 32'(htrans), has_addr ? 32'h2 : 32'h0);
      if (has_addr) begin
        chk("rnd haddr", haddr, pipe[pipe.size()-1].addr);
        chk("rnd hwrite", 32'(hwrite), 32'(pipe[pipe.size()-1].wr));
        chk("rnd hwstrb", 32'(hwstrb), 32'(pipe[pipe.size()-1].strb));
      end
      chk("rnd hwdata", hwdata, e_hw);
      chk("rnd rdata", rdata, e_rd);

      m_rdata = e_rd;
      if (abort) begin
        pipe.delete(); stalls = 0;
      end else if (hready) begin
        if (has_data) void'(pipe.pop_front());
        if (pipe.size() > 0) pipe[0].in_data = 1'b1;
        stalls = 0;
      end else if (has_data) begin
        stalls++;
      end
      if (e_gnt != 2'b00) begin
        nx.owner = win; nx.wr = pwr[win]; nx.addr = paddr[win];
        nx.strb = pstrb[win]; nx.wdata = pwd[win]; nx.in_data = 1'b0;
        pipe.push_back(nx);
        m_last = win;
      end
      for (int p = 0; p < 2; p++) begin
        if (pst[p] == 1 && e_gnt[p]) pst[p] = 2;
        else if (pst[p] == 2 && (e_done[p] || e_err[p])) pst[p] = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
